// File: rtl/ex_arbiter.sv
// Two-requester round-robin front end for a shared pipelined datapath.
// Accepted requester indices ride an in-order tag FIFO so that results route back to their owner.
module ex_arbiter #(
   parameter int DATA_W  = 32,
   parameter int MAX_OUT = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     s0_valid,
   input  logic                     s1_valid,
   input  logic [DATA_W-1:0]        s0_data,
   input  logic [DATA_W-1:0]        s1_data,
   output logic                     s0_ready,
   output logic                     s1_ready,
   output logic                     unit_ce,
   output logic [DATA_W-1:0]        unit_data_in,
   input  logic                     unit_data_valid,
   input  logic signed [DATA_W-1:0] unit_data_out,
   output logic                     r0_valid,
   output logic                     r1_valid,
   output logic signed [DATA_W-1:0] r_data,
   output logic                     busy,
   output logic                     err_orphan
);

   localparam int AW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int CW = $clog2(MAX_OUT + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUT);

   // Handshake: an operand transfers on a rising edge where sN_valid and sN_ready are both high;
   // results are one-cycle strobes with no backpressure.

   logic                     rr_q, rr_d;
   logic [CW-1:0]            count_q, count_d;
   logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
   logic [MAX_OUT-1:0]       tag_mem_q, tag_mem_d;
   logic                     unit_ce_q, unit_ce_d;
   logic [DATA_W-1:0]        unit_data_in_q, unit_data_in_d;
   logic                     r0_valid_q, r0_valid_d;
   logic                     r1_valid_q, r1_valid_d;
   logic signed [DATA_W-1:0] r_data_q, r_data_d;
   logic                     err_orphan_q, err_orphan_d;

   logic fifo_full;
   logic fifo_empty;
   logic can_take;
   logic grant0;
   logic grant1;
   logic push;
   logic push_tag;
   logic pop;
   logic head_tag;
   logic orphan;

   always_comb begin
      fifo_full  = (count_q == FULL_CNT);
      fifo_empty = (count_q == '0);
      can_take   = rst && !fifo_full;
      grant0     = can_take && s0_valid && (!s1_valid || !rr_q);
      grant1     = can_take && s1_valid && (!s0_valid || rr_q);
      push       = grant0 || grant1;
      push_tag   = grant1;
      // A result landing on an empty FIFO pairs with a tag being pushed in the same cycle.
      pop        = unit_data_valid && (!fifo_empty || push);
      head_tag   = fifo_empty ? push_tag : tag_mem_q[rd_ptr_q];
      orphan     = unit_data_valid && !pop;
   end

   assign s0_ready = grant0;
   assign s1_ready = grant1;

   always_comb begin
      rr_d           = rr_q;
      count_d        = count_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      tag_mem_d      = tag_mem_q;
      unit_ce_d      = push;
      unit_data_in_d = unit_data_in_q;
      r0_valid_d     = pop && !head_tag;
      r1_valid_d     = pop && head_tag;
      r_data_d       = r_data_q;
      err_orphan_d   = err_orphan_q || orphan;

      if (push) begin
         tag_mem_d[wr_ptr_q] = push_tag;
         wr_ptr_d            = wr_ptr_q + AW'(1);
         rr_d                = ~push_tag;
         unit_data_in_d      = grant0 ? s0_data : s1_data;
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         r_data_d = unit_data_out;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_q           <= 1'b0;
         count_q        <= '0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         tag_mem_q      <= '0;
         unit_ce_q      <= 1'b0;
         unit_data_in_q <= '0;
         r0_valid_q     <= 1'b0;
         r1_valid_q     <= 1'b0;
         r_data_q       <= '0;
         err_orphan_q   <= 1'b0;
      end else begin
         rr_q           <= rr_d;
         count_q        <= count_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         tag_mem_q      <= tag_mem_d;
         unit_ce_q      <= unit_ce_d;
         unit_data_in_q <= unit_data_in_d;
         r0_valid_q     <= r0_valid_d;
         r1_valid_q     <= r1_valid_d;
         r_data_q       <= r_data_d;
         err_orphan_q   <= err_orphan_d;
      end
   end

   assign unit_ce      = unit_ce_q;
   assign unit_data_in = unit_data_in_q;
   assign r0_valid     = r0_valid_q;
   assign r1_valid     = r1_valid_q;
   assign r_data       = r_data_q;
   assign busy         = (count_q != '0);
   assign err_orphan   = err_orphan_q;

endmodule

// File: tb/tb_ex_arbiter.sv
// Bench for ex_arbiter: directed scenarios plus random traffic against a queue-based model
// of arbitration, tag ordering and result routing.
module tb_ex_arbiter;

   localparam int DW  = 32;
   localparam int MO  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          s0_valid = 1'b0, s1_valid = 1'b0;
   logic [DW-1:0] s0_data = '0, s1_data = '0;
   logic          s0_ready, s1_ready;
   logic          unit_ce;
   logic [DW-1:0] unit_data_in;
   logic          unit_data_valid = 1'b0;
   logic [DW-1:0] unit_data_out = '0;
   logic          r0_valid, r1_valid;
   logic [DW-1:0] r_data;
   logic          busy, err_orphan;

   ex_arbiter #(.DATA_W(DW), .MAX_OUT(MO)) dut (
      .clk(clk), .rst(rst),
      .s0_valid(s0_valid), .s1_valid(s1_valid),
      .s0_data(s0_data), .s1_data(s1_data),
      .s0_ready(s0_ready), .s1_ready(s1_ready),
      .unit_ce(unit_ce), .unit_data_in(unit_data_in),
      .unit_data_valid(unit_data_valid), .unit_data_out(unit_data_out),
      .r0_valid(r0_valid), .r1_valid(r1_valid), .r_data(r_data),
      .busy(busy), .err_orphan(err_orphan)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: outstanding owners in arrival order, preferred requester, expected outputs.
   logic [0:0]    exp_q[$];
   int            pref_m;
   logic          exp_ce, exp_r0, exp_r1, exp_orphan;
   logic [DW-1:0] exp_din, exp_rdata;
   int            obs_grant;

   task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      pref_m     = 0;
      exp_ce     = 1'b0;
      exp_r0     = 1'b0;
      exp_r1     = 1'b0;
      exp_orphan = 1'b0;
      exp_din    = '0;
      exp_rdata  = '0;
   endtask

   task automatic check_outputs(input string where);
      check_eq({where, ".unit_ce"}, DW'(unit_ce), DW'(exp_ce));
      check_eq({where, ".unit_data_in"}, unit_data_in, exp_din);
      check_eq({where, ".r0_valid"}, DW'(r0_valid), DW'(exp_r0));
      check_eq({where, ".r1_valid"}, DW'(r1_valid), DW'(exp_r1));
      check_eq({where, ".r_data"}, r_data, exp_rdata);
      check_eq({where, ".busy"}, DW'(busy), DW'(exp_q.size() > 0));
      check_eq({where, ".err_orphan"}, DW'(err_orphan), DW'(exp_orphan));
   endtask

   // Asserts reset between clock edges (entered just after a falling edge), checks outputs clear
   // immediately and that nothing is accepted while held, then releases on a falling edge.
   task automatic reset_dut(input logic hold_valid);
      s0_valid        = hold_valid;
      s1_valid        = hold_valid;
      unit_data_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      model_clear();
      check_outputs("reset");
      check_eq("reset.s0_ready", DW'(s0_ready), '0);
      check_eq("reset.s1_ready", DW'(s1_ready), '0);
      repeat (2) @(negedge clk);
      rst      = 1'b1;
      s0_valid = 1'b0;
      s1_valid = 1'b0;
   endtask

   // One clock cycle: drive inputs, check readys, let the edge happen, check registered outputs.
   task automatic cyc(input logic v0, input logic v1, input logic [DW-1:0] d0,
                      input logic [DW-1:0] d1, input logic uv, input logic [DW-1:0] ud);
      logic full, g0, g1, push;
      logic [0:0] owner;
      s0_valid        = v0;
      s1_valid        = v1;
      s0_data         = d0;
      s1_data         = d1;
      unit_data_valid = uv;
      unit_data_out   = ud;
      #1;
      full = (exp_q.size() == MO);
      g0   = !full && v0 && (!v1 || pref_m == 0);
      g1   = !full && v1 && (!v0 || pref_m == 1);
      check_eq("s0_ready", DW'(s0_ready), DW'(g0));
      check_eq("s1_ready", DW'(s1_ready), DW'(g1));
      obs_grant = (s0_ready && s0_valid) ? 0 : (s1_ready && s1_valid) ? 1 : -1;
      @(posedge clk);
      push   = g0 || g1;
      exp_ce = push;
      exp_r0 = 1'b0;
      exp_r1 = 1'b0;
      if (push) begin
         exp_q.push_back(g1);
         exp_din = g0 ? d0 : d1;
         pref_m  = g0 ? 1 : 0;
      end
      if (uv) begin
         if (exp_q.size() > 0) begin
            owner     = exp_q.pop_front();
            exp_r0    = (owner == 1'b0);
            exp_r1    = (owner == 1'b1);
            exp_rdata = ud;
         end else begin
            exp_orphan = 1'b1;
         end
      end
      @(negedge clk);
      check_outputs("cycle");
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, '0, 1'b0, '0);
   endtask

   int grants[$];
   int n_acc;
   logic [DW-1:0] opa, opb;

   initial begin
      model_clear();
      @(negedge clk);
      reset_dut(1'b0);

      // Single operation from requester 0 with a negative result.
      cyc(1'b1, 1'b0, 32'h0000_0005, '0, 1'b0, '0);
      check_eq("single.unit_din", unit_data_in, 32'h0000_0005);
      cyc(1'b0, 1'b0, '0, '0, 1'b1, 32'hFFFF_FFF6);
      check_eq("single.r0", DW'(r0_valid), 32'd1);
      check_eq("single.busy", DW'(busy), 32'd0);
      idle(2);

      // Contention: both valid for 4 cycles, unit echoes with 2-cycle latency.
      reset_dut(1'b0);
      opa = 32'h1111_AAAA;
      opb = 32'h2222_BBBB;
      grants.delete();
      for (int c = 0; c < 8; c++) begin
         logic [DW-1:0] echo;
         echo = ((c - 3) % 2 == 0) ? opa : opb;
         cyc(c < 4, c < 4, opa, opb, (c >= 3 && c <= 6), (c >= 3 && c <= 6) ? echo : '0);
         if (obs_grant >= 0) grants.push_back(obs_grant);
      end
      check_eq("contention.n_grants", DW'(grants.size()), 32'd4);
      for (int i = 0; i < grants.size() && i < 4; i++)
         check_eq("contention.order", DW'(grants[i]), DW'(i % 2));

      // Full: unit silent, exactly MO accepts; one result frees one slot.
      reset_dut(1'b0);
      n_acc = 0;
      for (int c = 0; c < 7; c++) begin
         cyc(1'b1, 1'b1, 32'h100 + c, 32'h200 + c, 1'b0, '0);
         if (obs_grant >= 0) n_acc++;
      end
      check_eq("full.accepts", DW'(n_acc), DW'(MO));
      cyc(1'b1, 1'b1, 32'h300, 32'h400, 1'b1, 32'hCAFE_0001);
      check_eq("full.pop_cycle_accept", DW'(obs_grant + 1), 32'd0);
      n_acc = 0;
      for (int c = 0; c < 3; c++) begin
         cyc(1'b1, 1'b1, 32'h500 + c, 32'h600 + c, 1'b0, '0);
         if (obs_grant >= 0) n_acc++;
      end
      check_eq("full.refill", DW'(n_acc), 32'd1);
      for (int c = 0; c < MO; c++) cyc(1'b0, 1'b0, '0, '0, 1'b1, 32'hD000 + c);

      // Simultaneous push and pop at occupancy 2.
      reset_dut(1'b0);
      cyc(1'b1, 1'b0, 32'hA0, '0, 1'b0, '0);
      cyc(1'b0, 1'b1, '0, 32'hB0, 1'b0, '0);
      cyc(1'b1, 1'b0, 32'hA1, '0, 1'b1, 32'hE000_0001);
      check_eq("simul.r0", DW'(r0_valid), 32'd1);
      cyc(1'b0, 1'b0, '0, '0, 1'b1, 32'hE000_0002);
      check_eq("simul.r1", DW'(r1_valid), 32'd1);
      cyc(1'b0, 1'b0, '0, '0, 1'b1, 32'hE000_0003);
      check_eq("simul.drained", DW'(busy), 32'd0);

      // Orphan result is dropped and the flag sticks until reset.
      cyc(1'b0, 1'b0, '0, '0, 1'b1, 32'h0BAD_0BAD);
      check_eq("orphan.flag", DW'(err_orphan), 32'd1);
      idle(3);
      check_eq("orphan.sticky", DW'(err_orphan), 32'd1);

      // Reset mid-flight with 3 outstanding; late results become orphans.
      for (int c = 0; c < 3; c++) cyc(1'b1, 1'b1, 32'h700 + c, 32'h800 + c, 1'b0, '0);
      check_eq("midflight.busy", DW'(busy), 32'd1);
      reset_dut(1'b1);
      cyc(1'b1, 1'b1, 32'h900, 32'hA00, 1'b0, '0);
      check_eq("midflight.restart_s0", DW'(obs_grant), 32'd0);
      cyc(1'b0, 1'b0, '0, '0, 1'b1, 32'h1234);
      cyc(1'b0, 1'b0, '0, '0, 1'b1, 32'h5678);
      check_eq("midflight.orphan", DW'(err_orphan), 32'd1);

      // Random traffic with occasional resets.
      reset_dut(1'b0);
      for (int c = 0; c < 600; c++) begin
         if (c % 200 == 199) reset_dut($urandom_range(0, 1) == 1);
         cyc($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 60,
             $urandom, $urandom, $urandom_range(0, 99) < 45, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ex_arbiter.md
EX_ARBITER -- requirements
Module: ex_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width of the requester ports and the shared unit ports.
REQ-002 SHALL have parameter MAX_OUT, default 4, maximum number of outstanding operations (tag FIFO depth); power of two, 2..16.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have ports s0_valid, s1_valid  input  1  requester 0/1 has an operand.
REQ-006 SHALL have ports s0_data, s1_data  input  DATA_W  requester 0/1 operand.
REQ-007 SHALL have ports s0_ready, s1_ready  output  1  operand accepted this cycle when ready and valid are both high.
REQ-008 SHALL have port unit_ce  output  1  one-cycle issue strobe to the shared datapath.
REQ-009 SHALL have port unit_data_in  output  DATA_W  operand to the shared datapath.
REQ-010 SHALL have port unit_data_valid  input  1  result strobe from the shared datapath.
REQ-011 SHALL have port unit_data_out  input  DATA_W signed  result from the shared datapath.
REQ-012 SHALL have ports r0_valid, r1_valid  output  1  one-cycle result strobe to requester 0/1.
REQ-013 SHALL have port r_data  output  DATA_W signed  result data, shared by both requesters.
REQ-014 SHALL have port busy  output  1  high while the outstanding count is nonzero.
REQ-015 SHALL have port err_orphan  output  1  sticky flag: a result arrived with no outstanding tag.

Function
REQ-016 SHALL grant at most one requester per cycle; sN_ready is combinational from the valids, the round-robin pointer and FIFO-not-full.
REQ-017 SHALL use round-robin priority: pointer names the preferred requester; after an accept, pointer moves to the other requester; with no accept, pointer holds.
REQ-018 SHALL grant a lone valid requester regardless of pointer, if the FIFO is not full.
REQ-019 SHALL deassert both readys while the tag FIFO holds MAX_OUT entries, including in a cycle where a pop also occurs.
REQ-020 SHALL, on accept in cycle N, drive unit_ce=1 and unit_data_in=the accepted operand in cycle N+1, registered; otherwise unit_ce=0 and unit_data_in holds its last value.
REQ-021 SHALL push the accepted requester index (1 bit) into an in-order tag FIFO in the accept cycle.
REQ-022 SHALL, on unit_data_valid in cycle M with the FIFO nonempty, pop the head tag and drive r_data=unit_data_out and r<tag>_valid=1 in cycle M+1; the other rN_valid stays 0.
REQ-023 SHALL perform push and pop in the same cycle when both occur; occupancy stays unchanged.
REQ-024 SHALL, on unit_data_valid with the FIFO empty and no push in the same cycle, drop the result, keep both rN_valid at 0, and set err_orphan until reset.
REQ-025 SHALL wrap FIFO read/write pointers modulo MAX_OUT; occupancy counter range 0..MAX_OUT.
REQ-026 SHALL have no result backpressure; requesters must take rN_valid in the cycle it is presented.
REQ-027 SHALL drive busy=1 when occupancy>0, from the registered counter.

Reset
REQ-028 SHALL, on rst low, immediately clear: unit_ce=0, unit_data_in=0, r0_valid=r1_valid=0, r_data=0, busy=0, err_orphan=0, occupancy=0, FIFO pointers=0, round-robin pointer=0 (requester 0 preferred).
REQ-029 SHALL discard outstanding tags when reset asserts mid-operation; results arriving after reset release count as orphans (REQ-024).
REQ-030 SHALL accept nothing while rst is low (both readys 0).

Verification
REQ-031 Single: s0 presents 0x0000_0005 one cycle -> unit_ce high the next cycle with 0x5; unit returns 0xFFFF_FFF6 -> r0_valid one cycle later, r_data=0xFFFF_FFF6, r1_valid stays 0, busy falls.
REQ-032 Contention: s0 and s1 held valid for 4 cycles after reset, unit echoes with 2-cycle latency -> grants ordered s0,s1,s0,s1; results routed r0,r1,r0,r1 in order.
REQ-033 Full: both valid, unit never responds -> exactly MAX_OUT=4 accepts, then both readys 0; one unit_data_valid -> one result out, one further accept.
REQ-034 Simultaneous: occupancy 2, push and pop in the same cycle -> occupancy stays 2, correct tag routed.
REQ-035 Orphan: unit_data_valid with FIFO empty -> no rN_valid, err_orphan=1 and remains 1 until rst low.
REQ-036 Reset mid-flight: 3 outstanding, assert rst asynchronously between edges -> all outputs reset immediately, busy=0; arbitration restarts preferring s0.
